pll_reset_sequencer: RTL



---
 rtl/pll_reset_pkg.sv | 26 ++
 rtl/pll_reset_sequencer_if.sv | 23 ++
 rtl/pll_reset_sequencer_lock_sync.sv | 19 +
 rtl/pll_reset_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pll_reset_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
package pll_reset_pkg;

    localparam int SAT_W = 8;

    localparam int DEF_NUM_DOMAINS    = 4;
    localparam int DEF_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT   = 500000;
    localparam int DEF_PLL_RST_CYCLES = 16;
    localparam int DEF_STAGE_GAP      = 8;

    typedef enum logic [2:0] {
        ST_PLL_RESET,
        ST_WAIT_LOCK,
        ST_STABILIZE,
        ST_RELEASE,
        ST_RUN
    } pll_seq_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// PLL-side and domain-side signals of the reset sequencer.
interface pll_reset_sequencer_if
    import pll_reset_pkg::*;
#(
    parameter int NUM_DOMAINS = DEF_NUM_DOMAINS
);
    logic                   locked;
    logic                   pll_rst;
    logic [NUM_DOMAINS-1:0] rst_out;
    logic                   ready;
    logic [SAT_W-1:0]       lock_loss_count;
    logic [SAT_W-1:0]       retry_count;

    modport master (
        input  locked,
        output pll_rst, rst_out, ready, lock_loss_count, retry_count
    );

    modport slave (
        output locked,
        input  pll_rst, rst_out, ready, lock_loss_count, retry_count
    );
endinterface

// File: rtl/pll_reset_sequencer_lock_sync.sv
// Generic 2-flop synchroniser, synchronous reset to 0.
module lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset and staged domain-reset sequencer.
// Define PLL_RESET_RETRY_EN to enable lock-timeout retries of the PLL reset.
//
// state        | meaning
// PLL_RESET    | pll_rst held high for PLL_RST_CYCLES
// WAIT_LOCK    | waiting for locked_s (optional timeout -> retry)
// STABILIZE    | counting consecutive locked_s cycles
// RELEASE      | domain resets dropping every STAGE_GAP cycles
// RUN          | all domains out of reset, ready high
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int NUM_DOMAINS    = DEF_NUM_DOMAINS,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int STAGE_GAP      = DEF_STAGE_GAP
) (
    input  logic                  refclk,
    input  logic                  rst,
    pll_reset_sequencer_if.master bus
);
    localparam int CNT_W = $clog2(max3(LOCK_TIMEOUT, STABLE_CYCLES, NUM_DOMAINS * STAGE_GAP)) + 1;

    localparam logic [CNT_W-1:0] PRST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'((NUM_DOMAINS - 1) * STAGE_GAP);
    localparam logic [SAT_W-1:0] SAT_MAX      = '1;

    pll_seq_state_t         state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   locked_s;
    logic                   loss_inc;
    logic                   pll_rst_q, pll_rst_d;
    logic                   ready_q, ready_d;
    logic [NUM_DOMAINS-1:0] rst_out_q, rst_out_d;
    logic [SAT_W-1:0]       loss_q;

    lock_sync u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (bus.locked),
        .q   (locked_s)
    );

`ifdef PLL_RESET_RETRY_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    logic             retry_inc;
    logic [SAT_W-1:0] retry_q;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        loss_inc = 1'b0;
`ifdef PLL_RESET_RETRY_EN
        retry_inc = 1'b0;
`endif
        case (state_q)
            ST_PLL_RESET: begin
                if (cnt_q == PRST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = ST_STABILIZE;
                    cnt_d   = '0;
                end
`ifdef PLL_RESET_RETRY_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = ST_PLL_RESET;
                    cnt_d     = '0;
                    retry_inc = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_STABILIZE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == RELEASE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_d  = ST_WAIT_LOCK;
                    cnt_d    = '0;
                    loss_inc = 1'b1;
                end
            end
            default: begin
                state_d = ST_PLL_RESET;
                cnt_d   = '0;
            end
        endcase

        // Outputs are derived from the next state so they register alongside it.
        pll_rst_d = (state_d == ST_PLL_RESET);
        ready_d   = (state_d == ST_RUN);
        rst_out_d = '1;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            rst_out_d[i] = !((state_d == ST_RUN) ||
                             ((state_d == ST_RELEASE) && (cnt_d >= CNT_W'(i * STAGE_GAP))));
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= ST_PLL_RESET;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            rst_out_q <= '1;
            loss_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pll_rst_q <= pll_rst_d;
            ready_q   <= ready_d;
            rst_out_q <= rst_out_d;
            if (loss_inc && loss_q != SAT_MAX) begin
                loss_q <= loss_q + 1'b1;
            end
        end
    end

`ifdef PLL_RESET_RETRY_EN
    always_ff @(posedge refclk) begin
        if (rst) begin
            retry_q <= '0;
        end else if (retry_inc && retry_q != SAT_MAX) begin
            retry_q <= retry_q + 1'b1;
        end
    end
    assign bus.retry_count = retry_q;
`else
    assign bus.retry_count = '0;
`endif

    assign bus.pll_rst         = pll_rst_q;
    assign bus.ready           = ready_q;
    assign bus.rst_out         = rst_out_q;
    assign bus.lock_loss_count = loss_q;
endmodule
